comp_share_arb: RTL

- Time-shares one COMP comparator instance among NREQ requesters using round-robin arbitration.
- Latches the winning requester's operands and runs the unsigned compare on them.
- Returns registered gt/lt/eq flags with a one-cycle ack pulse to the granted requester.
- Sits between datapath control units and a single comparator resource in generated datapaths.

---
 rtl/comp_share_arb_pkg.sv | 14 +
 rtl/comp.sv | 19 +
 rtl/comp_share_arb_rr_pick.sv | 27 ++
 rtl/comp_share_arb.sv | 109 ++++++++++
 4 files changed

// File: rtl/comp_share_arb_pkg.sv
// rtl/comp_share_arb_pkg.sv - shared types and defaults for the shared comparator arbiter
package comp_share_arb_pkg;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_NREQ      = 4;

    // Encoding 2'd3 is unused and falls back to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/comp.sv
// rtl/comp.sv - combinational unsigned comparator resource
module COMP #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq
);

    // Unsigned magnitude compare
    always_comb begin
        gt = (a > b);
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/comp_share_arb_rr_pick.sv
// rtl/comp_share_arb_rr_pick.sv - combinational round-robin picker
module comp_share_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic            any,
    output logic [IDXW-1:0] winner
);

    logic [2*NREQ-1:0] dbl_req;

    // Scan the doubled request vector from rr_ptr upward so the wrap is a plain priority search
    always_comb begin
        dbl_req = {req, req};
        any     = 1'b0;
        winner  = '0;
        for (int i = 0; i < 2 * NREQ; i++) begin
            if (!any && (i >= int'(rr_ptr)) && dbl_req[i]) begin
                any    = 1'b1;
                winner = IDXW'((i >= NREQ) ? (i - NREQ) : i);
            end
        end
    end

endmodule

// File: rtl/comp_share_arb.sv
// rtl/comp_share_arb.sv - round-robin time-sharing of one comparator among requesters
module comp_share_arb
    import comp_share_arb_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NREQ      = DEF_NREQ,
    parameter int IDXW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_bus,
    input  logic [NREQ*DATAWIDTH-1:0] b_bus,
    output logic [NREQ-1:0]           ack,
    output logic                      gt,
    output logic                      lt,
    output logic                      eq,
    output logic [IDXW-1:0]           grant_idx,
    output logic                      busy
);

    arb_state_t            state;
    logic [IDXW-1:0]       rr_ptr;
    logic [IDXW-1:0]       next_ptr;
    logic [DATAWIDTH-1:0]  op_a;
    logic [DATAWIDTH-1:0]  op_b;
    logic                  pick_any;
    logic [IDXW-1:0]       pick_idx;
    logic                  c_gt;
    logic                  c_lt;
    logic                  c_eq;
    logic [NREQ-1:0]       ack_onehot;

    comp_share_arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .winner (pick_idx)
    );

    // The comparator only ever sees the latched operands, so late operand changes are ignored
    COMP #(
        .DATAWIDTH (DATAWIDTH)
    ) u_comp (
        .a  (op_a),
        .b  (op_b),
        .gt (c_gt),
        .lt (c_lt),
        .eq (c_eq)
    );

    // Pointer advance past the winner, and the ack pattern for the served requester
    always_comb begin
        next_ptr = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            ack_onehot[i] = (int'(grant_idx) == i);
        end
    end

    // Arbitration FSM: grant in IDLE, register the compare in CMP, pulse ack in ACK
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            ack       <= '0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            grant_idx <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        op_a      <= a_bus[int'(pick_idx)*DATAWIDTH +: DATAWIDTH];
                        op_b      <= b_bus[int'(pick_idx)*DATAWIDTH +: DATAWIDTH];
                        grant_idx <= pick_idx;
                        rr_ptr    <= next_ptr;
                        busy      <= 1'b1;
                        state     <= CMP;
                    end
                end
                CMP: begin
                    gt    <= c_gt;
                    lt    <= c_lt;
                    eq    <= c_eq;
                    ack   <= ack_onehot;
                    state <= ACK;
                end
                ACK: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
